ucsbece154b_prefetch_buffer: RTL

One-block sequential stream prefetcher between the instruction cache miss port and the SDRAM instruction-memory model. Forwards demand block fills from SDRAM to the icache. After every fill or buffer hit, it fetches the next sequential block into a one-block buffer. A later icache miss to that block is served from the buffer with no SDRAM access.

---
 rtl/ucsbece154b_prefetch_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ucsbece154b_prefetch_buffer.sv
// One-block sequential stream prefetcher between the icache miss port and
// the SDRAM instruction-memory model. Demand fills are forwarded to the icache;
// after every fill or buffer hit the next sequential block is fetched into a
// one-block buffer so that a later miss to it is served without SDRAM access.
module ucsbece154b_prefetch_buffer #(
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned WORD_SIZE   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           prefetchEnable,
  input  logic                           cacheReadRequest,
  input  logic [31:0]                    cacheReadAddress,
  output logic [WORD_SIZE-1:0]           cacheDataOut,
  output logic                           cacheDataReady,
  output logic [$clog2(BLOCK_WORDS)-1:0] cacheBlockIndex,
  output logic                           memReadRequest,
  output logic [31:0]                    memReadAddress,
  input  logic [WORD_SIZE-1:0]           memDataIn,
  input  logic                           memDataReady,
  input  logic [$clog2(BLOCK_WORDS)-1:0] memBlockIndex,
  output logic [15:0]                    pfHits
);

  localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
  localparam logic [31:0] BLOCK_BYTES = 32'(4 * BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, DEMAND, DRAIN, PREFETCH} state_t;

  state_t                 state;
  logic [31:0]            tag;
  logic                   valid;
  logic [BLOCK_WORDS-1:0] wvalid;
  logic [WORD_SIZE-1:0]   buffer [BLOCK_WORDS];
  logic [IDX_W-1:0]       word_cnt;
  logic [IDX_W-1:0]       drain_idx;
  logic                   issued;
  logic                   settle;

  logic [31:0]            req_block;
  logic [BLOCK_WORDS-1:0] wvalid_next;

  // Request block address and word-valid bits including the arriving word
  always_comb begin
    req_block   = cacheReadAddress & ~(BLOCK_BYTES - 32'd1);
    wvalid_next = wvalid | ({{(BLOCK_WORDS-1){1'b0}}, 1'b1} << memBlockIndex);
  end

  // Prefetcher FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      tag            <= '0;
      valid          <= 1'b0;
      wvalid         <= '0;
      for (int unsigned i = 0; i < BLOCK_WORDS; i++) buffer[i] <= '0;
      word_cnt       <= '0;
      drain_idx      <= '0;
      issued         <= 1'b0;
      settle         <= 1'b0;
      cacheDataOut   <= '0;
      cacheDataReady <= 1'b0;
      cacheBlockIndex <= '0;
      memReadRequest <= 1'b0;
      memReadAddress <= '0;
      pfHits         <= '0;
    end else begin
      cacheDataReady <= 1'b0;
      case (state)
        IDLE: begin
          // The settle cycle swallows the still-held request of a block that
          // was just delivered when no prefetch follows it.
          if (settle) begin
            settle <= 1'b0;
          end else if (cacheReadRequest) begin
            if (valid && tag == req_block) begin
              cacheDataOut    <= buffer[0];
              cacheDataReady  <= 1'b1;
              cacheBlockIndex <= '0;
              drain_idx       <= IDX_W'(1);
              if (pfHits != 16'hFFFF) pfHits <= pfHits + 16'd1;
              state           <= DRAIN;
            end else begin
              valid          <= 1'b0;
              memReadRequest <= 1'b1;
              memReadAddress <= req_block;
              word_cnt       <= '0;
              state          <= DEMAND;
            end
          end
        end
        DEMAND: begin
          if (memDataReady) begin
            memReadRequest  <= 1'b0;
            cacheDataOut    <= memDataIn;
            cacheDataReady  <= 1'b1;
            cacheBlockIndex <= memBlockIndex;
            word_cnt        <= word_cnt + IDX_W'(1);
            if (word_cnt == LAST_IDX) begin
              if (prefetchEnable) begin
                memReadAddress <= memReadAddress + BLOCK_BYTES;
                wvalid         <= '0;
                issued         <= 1'b0;
                state          <= PREFETCH;
              end else begin
                settle <= 1'b1;
                state  <= IDLE;
              end
            end
          end
        end
        DRAIN: begin
          cacheDataOut    <= buffer[drain_idx];
          cacheDataReady  <= 1'b1;
          cacheBlockIndex <= drain_idx;
          drain_idx       <= drain_idx + IDX_W'(1);
          if (drain_idx == LAST_IDX) begin
            valid <= 1'b0;
            if (prefetchEnable) begin
              memReadAddress <= tag + BLOCK_BYTES;
              wvalid         <= '0;
              issued         <= 1'b0;
              state          <= PREFETCH;
            end else begin
              settle <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        PREFETCH: begin
          // Request is raised one cycle after entry, i.e. the cycle after the
          // last demand/drain word is visible to the icache.
          if (!issued) begin
            memReadRequest <= 1'b1;
            issued         <= 1'b1;
          end else if (memDataReady) begin
            memReadRequest        <= 1'b0;
            buffer[memBlockIndex] <= memDataIn;
            wvalid                <= wvalid_next;
            if (&wvalid_next) begin
              valid <= 1'b1;
              tag   <= memReadAddress;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
